neopix_strip: RTL and testbench

Parametrised WS2812-style strip driver replacing the single-pixel `NEOPIX` path. Holds a `NUM_PIXELS` × 24-bit GRB frame buffer written from a simple write port. On a `START` strobe it streams the whole buffer to `DOUT` as back-to-back bit cells, applies a global brightness scale, then holds the latch/reset low time. It sits between pattern logic in `top` and the strip pin `PIN_18`.

---
 rtl/neopix_pkg.sv | 32 +++
 rtl/neopix_bitcell.sv | 35 +++
 rtl/neopix_strip.sv | 149 ++++++++++++++
 tb/tb_neopix_strip.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neopix_pkg.sv
// Shared types, default 16 MHz timing and the brightness scaler for the WS2812 strip driver.
package neopix_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SEND  = 2'd2,
        ST_LATCH = 2'd3
    } neopix_state_t;

    typedef logic [23:0] pixel_t;

    localparam int BIT_CYCLES_16M = 20;
    localparam int T0H_16M        = 6;
    localparam int T1H_16M        = 13;
    localparam int RESET_16M      = 4800;

    // Each channel becomes (c * (bright + 1)) >> 8, so 255 passes through and 0 blanks.
    function automatic pixel_t scale_pixel(input pixel_t px, input logic [7:0] bright);
        logic [15:0] gain;
        logic [15:0] prod;
        pixel_t      res;
        gain = {8'd0, bright} + 16'd1;
        res  = '0;
        for (int ch = 0; ch < 3; ch++) begin
            prod = {8'd0, px[ch*8 +: 8]} * gain;
            res[ch*8 +: 8] = prod[15:8];
        end
        return res;
    endfunction

endpackage

// File: rtl/neopix_bitcell.sv
// Generates one WS2812 bit cell per BIT_CYCLES while go is held; cells run back to back.
module neopix_bitcell #(
    parameter int BIT_CYCLES = 20,
    parameter int T0H_CYCLES = 6,
    parameter int T1H_CYCLES = 13
) (
    input  logic clk,
    input  logic rst_n,
    input  logic go,
    input  logic bit_val,
    output logic dout,
    output logic cell_last
);

    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] T0H      = CW'(T0H_CYCLES);
    localparam logic [CW-1:0] T1H      = CW'(T1H_CYCLES);

    logic [CW-1:0] cnt;

    // cell_last marks the cycle whose edge emits the final low slot of the cell.
    assign cell_last = go && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            dout <= 1'b0;
        end else begin
            dout <= go && (cnt < (bit_val ? T1H : T0H));
            cnt  <= (!go || cell_last) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/neopix_strip.sv
// WS2812 strip driver: frame buffer, brightness scaling and a START-triggered frame/latch sequencer.
module neopix_strip
    import neopix_pkg::*;
#(
    parameter int NUM_PIXELS   = 8,
    parameter int BIT_CYCLES   = BIT_CYCLES_16M,
    parameter int T0H_CYCLES   = T0H_16M,
    parameter int T1H_CYCLES   = T1H_16M,
    parameter int RESET_CYCLES = RESET_16M,
    localparam int AW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          WR_EN,
    input  logic [AW-1:0] WR_ADDR,
    input  logic [23:0]   WR_DATA,
    input  logic [7:0]    BRIGHT,
    input  logic          START,
    output logic          BUSY,
    output logic          FRAME_DONE,
    output logic          DOUT,
    output logic [1:0]    DBG_STATE
);

    localparam int RCW = $clog2(RESET_CYCLES + 1);
    localparam logic [AW-1:0]  LAST_PIX   = AW'(NUM_PIXELS - 1);
    localparam logic [AW:0]    NUM_PIX_W  = (AW+1)'(NUM_PIXELS);
    localparam logic [RCW-1:0] LATCH_LAST = RCW'(RESET_CYCLES - 1);
    localparam logic [RCW-1:0] LATCH_END  = RCW'(RESET_CYCLES);

    neopix_state_t  state;
    pixel_t         mem [NUM_PIXELS];
    pixel_t         rd_q;
    pixel_t         shreg;
    logic [AW-1:0]  rd_addr;
    logic [AW-1:0]  pix_idx;
    logic [4:0]     bit_idx;
    logic [7:0]     bright_q;
    logic [RCW-1:0] latch_cnt;
    logic           from_frame;
    logic           tail;
    logic           cell_go;
    logic           cell_last;

    // WR_EN and START are single-cycle strobes with no back-pressure: a write is
    // always taken (unless out of range); START is acted on only when BUSY is low.
    always_ff @(posedge CLK) begin
        if (WR_EN && ({1'b0, WR_ADDR} < NUM_PIX_W)) begin
            mem[WR_ADDR] <= WR_DATA;
        end
    end

    // While a pixel is sending, keep reading the next one so late writes still land.
    always_comb begin
        rd_addr = '0;
        if (state == ST_SEND && pix_idx != LAST_PIX) begin
            rd_addr = pix_idx + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        rd_q <= mem[rd_addr];
    end

    assign cell_go   = (state == ST_SEND) && !tail;
    assign DBG_STATE = state;

    neopix_bitcell #(
        .BIT_CYCLES (BIT_CYCLES),
        .T0H_CYCLES (T0H_CYCLES),
        .T1H_CYCLES (T1H_CYCLES)
    ) u_bitcell (
        .clk       (CLK),
        .rst_n     (RST_N),
        .go        (cell_go),
        .bit_val   (shreg[23]),
        .dout      (DOUT),
        .cell_last (cell_last)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= ST_LATCH;
            latch_cnt  <= '0;
            from_frame <= 1'b0;
            tail       <= 1'b0;
            shreg      <= '0;
            pix_idx    <= '0;
            bit_idx    <= '0;
            bright_q   <= '0;
            BUSY       <= 1'b1;
            FRAME_DONE <= 1'b0;
        end else begin
            FRAME_DONE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        bright_q <= BRIGHT;
                        pix_idx  <= '0;
                        BUSY     <= 1'b1;
                        state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    shreg   <= scale_pixel(rd_q, bright_q);
                    bit_idx <= '0;
                    tail    <= 1'b0;
                    state   <= ST_SEND;
                end
                ST_SEND: begin
                    // tail holds SEND for the final low slot so LATCH starts as the last cell ends.
                    if (tail) begin
                        tail       <= 1'b0;
                        latch_cnt  <= '0;
                        from_frame <= 1'b1;
                        state      <= ST_LATCH;
                    end else if (cell_last) begin
                        if (bit_idx == 5'd23) begin
                            if (pix_idx == LAST_PIX) begin
                                tail <= 1'b1;
                            end else begin
                                shreg   <= scale_pixel(rd_q, bright_q);
                                pix_idx <= pix_idx + 1'b1;
                                bit_idx <= '0;
                            end
                        end else begin
                            shreg   <= {shreg[22:0], 1'b0};
                            bit_idx <= bit_idx + 5'd1;
                        end
                    end
                end
                ST_LATCH: begin
                    if (latch_cnt == LATCH_END) begin
                        BUSY       <= 1'b0;
                        from_frame <= 1'b0;
                        state      <= ST_IDLE;
                    end else begin
                        latch_cnt <= latch_cnt + 1'b1;
                        if (latch_cnt == LATCH_LAST && from_frame) begin
                            FRAME_DONE <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_neopix_strip.sv
// Bench for neopix_strip: decodes DOUT into pixels and scores them against expected frames.
module tb_neopix_strip;

    localparam int NP        = 5;
    localparam int BITC      = 20;
    localparam int T0H       = 6;
    localparam int T1H       = 13;
    localparam int RST_C     = 1280;
    localparam int FRAME_CYC = NP * 24 * BITC + RST_C;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        WR_EN = 1'b0;
    logic [2:0]  WR_ADDR = '0;
    logic [23:0] WR_DATA = '0;
    logic [7:0]  BRIGHT = '0;
    logic        START = 1'b0;
    logic        BUSY;
    logic        FRAME_DONE;
    logic        DOUT;
    logic [1:0]  DBG_STATE;

    neopix_strip #(
        .NUM_PIXELS   (NP),
        .BIT_CYCLES   (BITC),
        .T0H_CYCLES   (T0H),
        .T1H_CYCLES   (T1H),
        .RESET_CYCLES (RST_C)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .WR_EN      (WR_EN),
        .WR_ADDR    (WR_ADDR),
        .WR_DATA    (WR_DATA),
        .BRIGHT     (BRIGHT),
        .START      (START),
        .BUSY       (BUSY),
        .FRAME_DONE (FRAME_DONE),
        .DOUT       (DOUT),
        .DBG_STATE  (DBG_STATE)
    );

    // clock / reset
    always #5 CLK = ~CLK;

    typedef struct {
        int          idx;
        logic [7:0]  bright;
        logic [23:0] pix;
        logic [23:0] exp_pix;
    } vec_t;

    vec_t        vecs [7];
    logic [23:0] exp_q [$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          fd_count = 0;
    int          fd_exp = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // DOUT decoder / scoreboard
    int          cyc = 0;
    int          hi_cnt = 0;
    int          pos = 0;
    int          bit_cnt = 0;
    int          cells_in_frame = 0;
    int          last_rise = 0;
    bit          cell_open = 1'b0;
    logic [23:0] word = '0;

    always @(negedge CLK) begin
        cyc++;
        if (!RST_N) begin
            cell_open      = 1'b0;
            bit_cnt        = 0;
            cells_in_frame = 0;
            word           = '0;
        end else begin
            if (FRAME_DONE) fd_count++;
            if (!cell_open) begin
                if (DOUT) begin
                    if (cells_in_frame > 0) check("cell_gap", cyc - last_rise, BITC);
                    last_rise = cyc;
                    cell_open = 1'b1;
                    hi_cnt    = 1;
                    pos       = 1;
                end
            end else begin
                pos++;
                if (DOUT) hi_cnt++;
                if (pos == BITC) begin
                    cell_open = 1'b0;
                    if (hi_cnt != T0H && hi_cnt != T1H) check("cell_width", hi_cnt, T0H);
                    word = {word[22:0], (hi_cnt == T1H)};
                    bit_cnt++;
                    cells_in_frame++;
                    if (cells_in_frame == NP * 24) cells_in_frame = 0;
                    if (bit_cnt == 24) begin
                        bit_cnt = 0;
                        if (exp_q.size() == 0) check("unexpected_pixel", word, 32'hFFFF_FFFF);
                        else check("pixel", word, exp_q.pop_front());
                    end
                end
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic write_px(input int a, input logic [23:0] d);
        WR_EN   = 1'b1;
        WR_ADDR = a[2:0];
        WR_DATA = d;
        tick();
        WR_EN = 1'b0;
    endtask

    task automatic load5(input logic [23:0] p0, p1, p2, p3, p4);
        write_px(0, p0);
        write_px(1, p1);
        write_px(2, p2);
        write_px(3, p3);
        write_px(4, p4);
    endtask

    task automatic push5(input logic [23:0] p0, p1, p2, p3, p4);
        exp_q.push_back(p0);
        exp_q.push_back(p1);
        exp_q.push_back(p2);
        exp_q.push_back(p3);
        exp_q.push_back(p4);
    endtask

    task automatic start_frame(input logic [7:0] b);
        BRIGHT = b;
        START  = 1'b1;
        tick();
        START = 1'b0;
        check("busy_after_start", BUSY, 1);
        check("dout_low_n", DOUT, 0);
        tick();
        check("dout_low_n1", DOUT, 0);
        tick();
        check("first_rise_n2", DOUT, 1);
    endtask

    task automatic finish_frame(input int elapsed);
        int c;
        c = elapsed;
        while (!FRAME_DONE && c < FRAME_CYC + 500) begin
            tick();
            c++;
        end
        check("rise_to_frame_done", c, FRAME_CYC);
        tick();
        fd_exp++;
        check("busy_fall", BUSY, 0);
        check("frame_done_pulse", FRAME_DONE, 0);
        check("idle_state", DBG_STATE, 0);
        check("frame_done_count", fd_count, fd_exp);
        check("sb_drained", exp_q.size(), 0);
    endtask

    task automatic post_reset_latch();
        int bad;
        bad = 0;
        for (int i = 0; i < RST_C; i++) begin
            tick();
            if (BUSY !== 1'b1 || DOUT !== 1'b0 || FRAME_DONE !== 1'b0) bad++;
        end
        check("post_reset_latch_cycles", bad, 0);
        tick();
        check("post_reset_busy_fall", BUSY, 0);
        check("post_reset_no_frame_done", fd_count, fd_exp);
    endtask

    initial begin
        #2_000_000;
        n_bad++;
        $display("FAIL watchdog: got timeout expected summary");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        int bad;
        vecs[0] = '{0, 8'd255, 24'h00FF00, 24'h00FF00};
        vecs[1] = '{0, 8'd127, 24'h00FF00, 24'h007F00};
        vecs[2] = '{0, 8'd0,   24'h00FF00, 24'h000000};
        vecs[3] = '{2, 8'd64,  24'h1020FF, 24'h040840};
        vecs[4] = '{4, 8'd200, 24'hA55A01, 24'h814600};
        vecs[5] = '{1, 8'd1,   24'hFFFFFF, 24'h010101};
        vecs[6] = '{3, 8'd255, 24'hFFFFFF, 24'hFFFFFF};

        repeat (3) tick();
        check("rst_busy", BUSY, 1);
        check("rst_dout", DOUT, 0);
        check("rst_frame_done", FRAME_DONE, 0);
        check("rst_state", DBG_STATE, 3);
        RST_N = 1'b1;
        post_reset_latch();

        for (int v = 0; v < 7; v++) begin
            for (int p = 0; p < NP; p++) begin
                write_px(p, (p == vecs[v].idx) ? vecs[v].pix : 24'h0);
                exp_q.push_back((p == vecs[v].idx) ? vecs[v].exp_pix : 24'h0);
            end
            start_frame(vecs[v].bright);
            finish_frame(0);
        end

        // START and out-of-range writes while busy are dropped
        load5(24'hC0FFEE, 24'h123456, 24'h000000, 24'h000000, 24'h800001);
        push5(24'hC0FFEE, 24'h123456, 24'h000000, 24'h000000, 24'h800001);
        start_frame(8'd255);
        repeat (300) tick();
        START   = 1'b1;
        WR_EN   = 1'b1;
        WR_ADDR = 3'd5;
        WR_DATA = 24'hFFFFFF;
        tick();
        START   = 1'b0;
        WR_ADDR = 3'd7;
        tick();
        WR_EN = 1'b0;
        finish_frame(302);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (BUSY !== 1'b0 || DOUT !== 1'b0) bad++;
        end
        check("start_not_queued", bad, 0);
        check("single_frame_done", fd_count, fd_exp);

        // mid-frame writes: pixel 3 lands this frame, pixel 0 only next frame
        load5(24'h111111, 24'h222222, 24'h333333, 24'h444444, 24'h555555);
        push5(24'h111111, 24'h222222, 24'h333333, 24'hABCDEF, 24'h555555);
        start_frame(8'd255);
        repeat (580) tick();
        write_px(3, 24'hABCDEF);
        write_px(0, 24'h0F0F0F);
        finish_frame(582);
        push5(24'h0F0F0F, 24'h222222, 24'h333333, 24'hABCDEF, 24'h555555);
        start_frame(8'd255);
        finish_frame(0);

        // reset during pixel 2 while DOUT is high
        push5(24'h0F0F0F, 24'h222222, 24'h333333, 24'hABCDEF, 24'h555555);
        start_frame(8'd255);
        repeat (1002) tick();
        check("pre_reset_dout_high", DOUT, 1);
        #2;
        RST_N = 1'b0;
        #1;
        check("async_reset_dout", DOUT, 0);
        check("async_reset_busy", BUSY, 1);
        check("async_reset_state", DBG_STATE, 3);
        exp_q.delete();
        repeat (3) tick();
        RST_N = 1'b1;
        post_reset_latch();
        push5(24'h0F0F0F, 24'h222222, 24'h333333, 24'hABCDEF, 24'h555555);
        start_frame(8'd255);
        finish_frame(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
